vga_scan_engine: RTL
====================

# vga_scan_engine

Parametrised VGA raster timing generator and pixel pipeline, the next generation of the fixed 800x600 controller. Generates H/V sync, blank and pixel-request strobes for any mode set via parameters, publishes active-pixel coordinates alongside each request, and supports a 2x pixel/line replication (zoom) mode latched at frame boundaries. Sits between the frame-buffer/line-buffer reader (host side) and the ADV7123 DAC pins.

## Interface

- H_SYNC, 128: hsync pulse width, pixels
- H_BACK, 88: horizontal back porch
- H_ACT, 800: active pixels per line
- H_FRONT, 40: horizontal front porch
- V_SYNC, 4 / V_BACK, 23 / V_ACT, 600 / V_FRONT, 1: vertical equivalents, lines
- H_POL, 0 / V_POL, 0: sync active level (0 = active-low)
- COLOR_W, 10: bits per colour channel
- REQ_LEAD, 2: cycles from oRequest to pixel on DAC pins; legal range 2..8
- CNT_W, 12: counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

- iCLK  in  1  pixel clock
- iRST_N  in  1  asynchronous active-low reset
- iZOOM_MODE_SW  in  1  1 = 2x replication mode; sampled at frame start only
- iRed, iGreen, iBlue  in  COLOR_W  host pixel data
- oRequest  out  1  host must deliver pixel (oX,oY)
- oX, oY  out  CNT_W  source coordinate of requested pixel, valid with oRequest
- oFrameStart  out  1  one-cycle pulse, first cycle of frame (H=0,V=0)
- oLineStart  out  1  one-cycle pulse, every H=0
- oVGA_R, oVGA_G, oVGA_B  out  COLOR_W  DAC data, 0 outside active area
- oVGA_H_SYNC, oVGA_V_SYNC  out  1  syncs, polarity per H_POL/V_POL
- oVGA_BLANK  out  1  high in active area only (DAC BLANK_N)
- oVGA_SYNC  out  1  constant 0

## Operation

- H_TOTAL = sum of H params; h counts 0..H_TOTAL-1 then wraps to 0 (exactly H_TOTAL states). v increments on h wrap, counts 0..V_TOTAL-1, wraps.
- Sync asserted for h < H_SYNC (v < V_SYNC). Active: X0=H_SYNC+H_BACK <= h < X0+H_ACT and Y0=V_SYNC+V_BACK <= v < Y0+V_ACT.
- Zoom mode register: loads iZOOM_MODE_SW when h=H_TOTAL-1 and v=V_TOTAL-1; held for whole frame. Mid-frame switch changes nothing until next frame.
- Normal mode: oRequest for every active pixel; oX = h-X0, oY = v-Y0.
- Zoom mode: oRequest only for even active x; oX = x>>1, oY = y>>1 (each source line requested twice). Block holds the captured colour for two displayed pixels. Active region covers H_ACT/2 x V_ACT/2 source pixels.
- oX/oY hold last value when oRequest low.
- Reset (async): counters, zoom reg, colour pipeline to 0; oRequest, oFrameStart, oLineStart, oVGA_BLANK, colours, oX, oY = 0; syncs at inactive level. First frame starts at h=0,v=0 after release.

## Timing

- All outputs registered. Let D(x) = cycle pixel x appears on oVGA_*. Syncs and oVGA_BLANK are aligned to the same cycle as data.
- oRequest with oX=x high in cycle D(x)-REQ_LEAD; host data sampled at edge ending cycle D(x)-1 (host read latency REQ_LEAD-1 cycles; default 1).
- oFrameStart/oLineStart aligned with sync outputs (same cycle hsync first asserts).
- First active pixel of a line: oVGA_BLANK rises exactly at D(0); falls after D(H_ACT-1).

## Structure

- Package vga_scan_pkg: timing parameter struct/typedef, SVGA_800x600 and VGA_640x480 preset constants, function computing totals.
- Sub-module vga_scan_counter (h/v counters, wrap, region flags); top handles request delay line (REQ_LEAD-deep shift of active flag), zoom hold and output registers.

## Test plan

- Small mode (H 2/2/8/2, V 1/1/4/1), REQ_LEAD=2: hsync low 2 cycles per 14-cycle line, vsync 1 of 7 lines; line period exactly 14 cycles.
- Host returns x as colour, 1-cycle latency -> oVGA_R shows 0..7 on consecutive active cycles, 0 elsewhere, oVGA_BLANK high exactly those 8 cycles.
- REQ_LEAD=4 with 3-cycle host latency -> same pixel sequence, no shift.
- Zoom on at frame start -> 4 requests/line, oX 0..3, oY 0,0,1,1; output pairs 0,0,1,1,2,2,3,3.
- Toggle iZOOM_MODE_SW mid-frame -> behaviour unchanged until oFrameStart, then switches.
- Assert iRST_N low mid-line -> all outputs at reset values immediately; after release first oFrameStart after one full H_TOTAL*V_TOTAL... first frame begins at h=0, oFrameStart within 1 cycle.

Source files
------------

// File: rtl/vga_scan_pkg.sv
// vga_scan_pkg: VGA timing description type, mode presets and total helpers
package vga_scan_pkg;

   typedef struct packed {
      int hSync;
      int hBack;
      int hAct;
      int hFront;
      int vSync;
      int vBack;
      int vAct;
      int vFront;
   } vgaTiming_t;

   localparam vgaTiming_t SVGA_800x600 = '{128, 88, 800, 40, 4, 23, 600, 1};
   localparam vgaTiming_t VGA_640x480  = '{96, 48, 640, 16, 2, 33, 480, 10};

   function automatic int hTotal(vgaTiming_t t);
      return t.hSync + t.hBack + t.hAct + t.hFront;
   endfunction

   function automatic int vTotal(vgaTiming_t t);
      return t.vSync + t.vBack + t.vAct + t.vFront;
   endfunction

endpackage

// File: rtl/vga_scan_engine_if.sv
// vga_scan_engine_if: pixel request/response bus between scan engine and host reader
interface vga_scan_engine_if #(
   parameter int COLOR_W = 10,
   parameter int CNT_W   = 12
);
   logic [COLOR_W-1:0] iRed;
   logic [COLOR_W-1:0] iGreen;
   logic [COLOR_W-1:0] iBlue;
   logic               oRequest;
   logic [CNT_W-1:0]   oX;
   logic [CNT_W-1:0]   oY;
   logic               oFrameStart;
   logic               oLineStart;

   modport master (
      input  iRed, iGreen, iBlue,
      output oRequest, oX, oY, oFrameStart, oLineStart
   );

   modport slave (
      output iRed, iGreen, iBlue,
      input  oRequest, oX, oY, oFrameStart, oLineStart
   );
endinterface

// File: rtl/vga_scan_counter.sv
// vga_scan_counter: h/v raster counters with sync flags and a lead-shifted request window
module vga_scan_counter
   import vga_scan_pkg::*;
#(
   parameter vgaTiming_t TIMING   = SVGA_800x600,
   parameter int         REQ_LEAD = 2,
   parameter int         CNT_W    = 12
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   output logic [CNT_W-1:0] hCnt,
   output logic [CNT_W-1:0] vCnt,
   output logic             hSyncOn,
   output logic             vSyncOn,
   output logic             reqWin,
   output logic             frameEnd
);
   localparam int RX0 = TIMING.hSync + TIMING.hBack - REQ_LEAD;
   localparam int Y0  = TIMING.vSync + TIMING.vBack;

   logic lineEnd;

   assign lineEnd  = hCnt == CNT_W'(hTotal(TIMING) - 1);
   assign frameEnd = lineEnd && vCnt == CNT_W'(vTotal(TIMING) - 1);
   assign hSyncOn  = hCnt < CNT_W'(TIMING.hSync);
   assign vSyncOn  = vCnt < CNT_W'(TIMING.vSync);
   // window runs REQ_LEAD pixels ahead of the active area, staying on the same line
   assign reqWin   = hCnt >= CNT_W'(RX0) && hCnt < CNT_W'(RX0 + TIMING.hAct) &&
                     vCnt >= CNT_W'(Y0) && vCnt < CNT_W'(Y0 + TIMING.vAct);

   // h advances every pixel and wraps after H_TOTAL states; v steps on each h wrap
   always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) begin
         hCnt <= '0;
         vCnt <= '0;
      end else begin
         hCnt <= lineEnd ? '0 : hCnt + 1'b1;
         vCnt <= frameEnd ? '0 : lineEnd ? vCnt + 1'b1 : vCnt;
      end

endmodule

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: parametrised VGA timing generator with lead-time pixel requests and 2x zoom
module vga_scan_engine
   import vga_scan_pkg::*;
#(
   parameter int H_SYNC   = 128,
   parameter int H_BACK   = 88,
   parameter int H_ACT    = 800,
   parameter int H_FRONT  = 40,
   parameter int V_SYNC   = 4,
   parameter int V_BACK   = 23,
   parameter int V_ACT    = 600,
   parameter int V_FRONT  = 1,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int COLOR_W  = 10,
   parameter int REQ_LEAD = 2,
   parameter int CNT_W    = 12
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iZOOM_MODE_SW,
   vga_scan_engine_if.master  host,
   output logic [COLOR_W-1:0] oVGA_R,
   output logic [COLOR_W-1:0] oVGA_G,
   output logic [COLOR_W-1:0] oVGA_B,
   output logic               oVGA_H_SYNC,
   output logic               oVGA_V_SYNC,
   output logic               oVGA_BLANK,
   output logic               oVGA_SYNC
);
   localparam vgaTiming_t TIMING = '{H_SYNC, H_BACK, H_ACT, H_FRONT, V_SYNC, V_BACK, V_ACT, V_FRONT};
   localparam int X0 = H_SYNC + H_BACK;
   localparam int Y0 = V_SYNC + V_BACK;

   logic [CNT_W-1:0]    hCnt, vCnt, srcX, srcY;
   logic                hSyncOn, vSyncOn, reqWin, frameEnd, zoom, reqNow;
   logic [REQ_LEAD-1:0] actPipe, reqPipe;

   vga_scan_counter #(
      .TIMING   (TIMING),
      .REQ_LEAD (REQ_LEAD),
      .CNT_W    (CNT_W)
   ) u_counter (
      .iCLK     (iCLK),
      .iRST_N   (iRST_N),
      .hCnt     (hCnt),
      .vCnt     (vCnt),
      .hSyncOn  (hSyncOn),
      .vSyncOn  (vSyncOn),
      .reqWin   (reqWin),
      .frameEnd (frameEnd)
   );

   assign srcX          = hCnt + CNT_W'(REQ_LEAD) - CNT_W'(X0);
   assign srcY          = vCnt - CNT_W'(Y0);
   assign reqNow        = reqWin && !(zoom && srcX[0]);
   assign host.oRequest = reqPipe[0];
   assign oVGA_SYNC     = 1'b0;

   // zoom latches at the last pixel of a frame; request/active flags ride a REQ_LEAD-deep
   // delay line so the DAC stage loads host data the cycle before the pixel is shown
   always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) begin
         zoom             <= 1'b0;
         actPipe          <= '0;
         reqPipe          <= '0;
         host.oX          <= '0;
         host.oY          <= '0;
         host.oFrameStart <= 1'b0;
         host.oLineStart  <= 1'b0;
         oVGA_H_SYNC      <= !H_POL;
         oVGA_V_SYNC      <= !V_POL;
         oVGA_BLANK       <= 1'b0;
         oVGA_R           <= '0;
         oVGA_G           <= '0;
         oVGA_B           <= '0;
      end else begin
         zoom             <= frameEnd ? iZOOM_MODE_SW : zoom;
         actPipe          <= {actPipe[REQ_LEAD-2:0], reqWin};
         reqPipe          <= {reqPipe[REQ_LEAD-2:0], reqNow};
         host.oX          <= reqNow ? (zoom ? srcX >> 1 : srcX) : host.oX;
         host.oY          <= reqNow ? (zoom ? srcY >> 1 : srcY) : host.oY;
         host.oFrameStart <= hCnt == '0 && vCnt == '0;
         host.oLineStart  <= hCnt == '0;
         oVGA_H_SYNC      <= hSyncOn ? H_POL : !H_POL;
         oVGA_V_SYNC      <= vSyncOn ? V_POL : !V_POL;
         oVGA_BLANK       <= actPipe[REQ_LEAD-1];
         oVGA_R           <= actPipe[REQ_LEAD-1] ? (reqPipe[REQ_LEAD-1] ? host.iRed : oVGA_R) : '0;
         oVGA_G           <= actPipe[REQ_LEAD-1] ? (reqPipe[REQ_LEAD-1] ? host.iGreen : oVGA_G) : '0;
         oVGA_B           <= actPipe[REQ_LEAD-1] ? (reqPipe[REQ_LEAD-1] ? host.iBlue : oVGA_B) : '0;
      end

endmodule
